// File: rtl/seq_binary2bcd.sv
// Iterative binary-to-BCD converter (shift-and-add-3). One input bit is processed per clock.
// Latency: BIN_WIDTH cycles from the accepted start edge to the done pulse.
// Backpressure: no queueing; start is only sampled while idle and is ignored while busy.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - conversion request, accepted only while idle
//   bin      - unsigned binary input, captured on the accepting edge
//   busy     - high while a conversion runs (exactly BIN_WIDTH cycles)
//   done     - one-cycle pulse when bcd/overflow hold a new result
//   bcd      - packed BCD result, digit 0 in bits [3:0]
//   overflow - last result was >= 10^DIGITS (bcd then holds value mod 10^DIGITS)
module seq_binary2bcd #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state;
    logic [BIN_WIDTH-1:0]  bin_sr;
    logic [4*DIGITS-1:0]   work;
    logic [4*DIGITS-1:0]   work_adj;
    logic [4*DIGITS-1:0]   work_nxt;
    logic                  sticky;
    logic                  sticky_nxt;
    logic [CW-1:0]         cnt;

    // Per-digit add-3 correction, then one left shift of {work, bin_sr}.
    // The bit leaving the top digit stands for a multiple of 10^DIGITS, so it
    // is accumulated into the sticky overflow flag instead of being kept.
    always_comb begin
        work_adj = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5) begin
                work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
            end
        end
        work_nxt   = {work_adj[4*DIGITS-2:0], bin_sr[BIN_WIDTH-1]};
        sticky_nxt = sticky | work_adj[4*DIGITS-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            work     <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        work   <= '0;
                        sticky <= 1'b0;
                        cnt    <= CW'(BIN_WIDTH);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_sr <= bin_sr << 1;
                    work   <= work_nxt;
                    sticky <= sticky_nxt;
                    cnt    <= cnt - CW'(1);
                    // Last bit: publish the result on the same edge that
                    // returns to IDLE, so start in the done cycle is accepted.
                    if (cnt == CW'(1)) begin
                        bcd      <= work_nxt;
                        overflow <= sticky_nxt;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_binary2bcd.sv
module tb_seq_binary2bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // instance 0: BIN_WIDTH=8,  DIGITS=2
    logic        start0, busy0, done0, ovf0;
    logic [7:0]  bin0, bcd0;
    // instance 1: BIN_WIDTH=10, DIGITS=3
    logic        start1, busy1, done1, ovf1;
    logic [9:0]  bin1;
    logic [11:0] bcd1;
    // instance 2: BIN_WIDTH=8,  DIGITS=3
    logic        start2, busy2, done2, ovf2;
    logic [7:0]  bin2;
    logic [11:0] bcd2;

    seq_binary2bcd #(.BIN_WIDTH(8), .DIGITS(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0));
    seq_binary2bcd #(.BIN_WIDTH(10), .DIGITS(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1));
    seq_binary2bcd #(.BIN_WIDTH(8), .DIGITS(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2));

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits of v mod 10^d, overflow when v >= 10^d.
    function automatic logic [31:0] ref_bcd(input int v, input int d);
        int p = 1;
        int m;
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) p = p * 10;
        m = v % p;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit ref_ovf(input int v, input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return v >= p;
    endfunction

    task automatic drive(input int inst, input logic st, input int v);
        case (inst)
            0: begin start0 = st; bin0 = 8'(v); end
            1: begin start1 = st; bin1 = 10'(v); end
            default: begin start2 = st; bin2 = 8'(v); end
        endcase
    endtask

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done0 : (inst == 1) ? done1 : done2;
    endfunction
    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy0 : (inst == 1) ? busy1 : busy2;
    endfunction
    function automatic logic get_ovf(input int inst);
        return (inst == 0) ? ovf0 : (inst == 1) ? ovf1 : ovf2;
    endfunction
    function automatic logic [31:0] get_bcd(input int inst);
        return (inst == 0) ? {24'b0, bcd0} : (inst == 1) ? {20'b0, bcd1} : {20'b0, bcd2};
    endfunction

    // One full conversion; bin is scrambled right after acceptance.
    task automatic run_conv(input int inst, input int bw, input int v,
                            input logic [31:0] exp_bcd, input logic exp_ovf, input string tag);
        int lat = 0;
        int bcnt = 0;
        drive(inst, 1'b1, v);
        @(posedge clk); #1;
        drive(inst, 1'b0, ~v);
        while (!get_done(inst) && lat < 4 * bw + 10) begin
            if (get_busy(inst)) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, bw);
        check({tag, " busy_cycles"}, bcnt, bw);
        check({tag, " bcd"}, get_bcd(inst), exp_bcd);
        check({tag, " overflow"}, {31'b0, get_ovf(inst)}, {31'b0, exp_ovf});
        check({tag, " busy_at_done"}, {31'b0, get_busy(inst)}, 0);
        @(posedge clk); #1;
        check({tag, " done_width"}, {31'b0, get_done(inst)}, 0);
    endtask

    typedef struct {
        int          inst;
        int          bw;
        int          v;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    initial begin
        vec_t vt[$];
        int   lat, extra, nd, hold_bad, v;
        int   idx[2];
        logic [31:0] res[2];

        rst_n = 1'b0;
        drive(0, 1'b0, 0); drive(1, 1'b0, 0); drive(2, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy0}, 0);
        check("reset done", {31'b0, done0}, 0);
        check("reset bcd", {24'b0, bcd0}, 0);
        check("reset overflow", {31'b0, ovf0}, 0);
        check("reset bcd u1", {20'b0, bcd1}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: hand-derived expected values
        vt.push_back('{0, 8,   82, 32'h82,  1'b0});
        vt.push_back('{0, 8,   99, 32'h99,  1'b0});
        vt.push_back('{0, 8,  100, 32'h00,  1'b1});
        vt.push_back('{0, 8,  255, 32'h55,  1'b1});
        vt.push_back('{0, 8,    0, 32'h00,  1'b0});
        vt.push_back('{1, 10, 1023, 32'h023, 1'b1});
        vt.push_back('{1, 10,  999, 32'h999, 1'b0});
        vt.push_back('{1, 10, 1000, 32'h000, 1'b1});
        vt.push_back('{2, 8,   255, 32'h255, 1'b0});
        vt.push_back('{2, 8,     0, 32'h000, 1'b0});
        foreach (vt[i]) begin
            run_conv(vt[i].inst, vt[i].bw, vt[i].v, vt[i].exp_bcd, vt[i].exp_ovf,
                     $sformatf("vec%0d(%0d)", i, vt[i].v));
        end

        // start while busy is ignored
        drive(0, 1'b1, 37);
        @(posedge clk); #1;
        drive(0, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b1, 200);
        @(posedge clk); #1;
        drive(0, 1'b0, 0);
        lat = 3;
        while (!done0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore latency", lat, 8);
        check("ignore bcd", {24'b0, bcd0}, 32'h37);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0) extra++;
        end
        check("ignore extra_done", extra, 0);

        // start held high, bin changed during the first conversion
        drive(0, 1'b1, 12);
        @(posedge clk); #1;
        bin0 = 8'd45;
        nd = 0; hold_bad = 0;
        idx[0] = 0; idx[1] = 0; res[0] = '0; res[1] = '0;
        for (int c = 0; c < 40; c++) begin
            if (done0) begin
                idx[nd] = c;
                res[nd] = {24'b0, bcd0};
                nd++;
                if (nd == 2) begin
                    start0 = 1'b0;
                    break;
                end
            end else if (nd == 1 && bcd0 !== 8'h12) begin
                hold_bad++;
            end
            @(posedge clk); #1;
        end
        check("held done_count", nd, 2);
        check("held first_latency", idx[0], 8);
        check("held spacing", idx[1] - idx[0], 9);
        check("held result1", res[0], 32'h12);
        check("held result2", res[1], 32'h45);
        check("held hold_between", hold_bad, 0);
        repeat (12) @(posedge clk);
        #1;

        // reset in the middle of a conversion
        drive(0, 1'b1, 77);
        @(posedge clk); #1;
        drive(0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset busy", {31'b0, busy0}, 0);
        check("midreset bcd", {24'b0, bcd0}, 0);
        check("midreset overflow", {31'b0, ovf0}, 0);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done0) extra++;
        end
        check("midreset no_done", extra, 0);
        run_conv(0, 8, 77, 32'h77, 1'b0, "after_reset");

        // randomized against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(0, 255);
            run_conv(0, 8, v, ref_bcd(v, 2), ref_ovf(v, 2), $sformatf("rnd0(%0d)", v));
        end
        for (int i = 0; i < 10; i++) begin
            v = $urandom_range(0, 1023);
            run_conv(1, 10, v, ref_bcd(v, 3), ref_ovf(v, 3), $sformatf("rnd1(%0d)", v));
        end
        for (int i = 0; i < 10; i++) begin
            v = $urandom_range(0, 255);
            run_conv(2, 8, v, ref_bcd(v, 3), ref_ovf(v, 3), $sformatf("rnd2(%0d)", v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
